thr_to_pry_pipe: RTL and testbench

- Streaming thermometer-to-priority decoder. It is the inverse of the priority-to-thermometer conversion.
- Accepts a thermometer-coded vector on a valid/ready input stream and returns three results on a valid/ready output stream, after a 2-stage registered pipeline with full backpressure:
  - a one-hot priority vector,
  - the binary index of that vector,
  - a legality flag.
- Keeps a saturating count of illegal (non-monotonic) thermometer codes, for debug.

---
 rtl/thr_to_pry_pipe.sv | 164 ++++++++++++++++
 tb/tb_thr_to_pry_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thr_to_pry_pipe.sv
// -----------------------------------------------------------------------------
// thr_to_pry_pipe
//
// Streaming thermometer-to-priority decoder: the inverse of a
// priority-to-thermometer conversion. A thermometer code arrives on a
// valid/ready input stream. Three results leave on a valid/ready output
// stream after two registered stages with full backpressure:
//   - a one-hot vector of the lowest set bit,
//   - the binary index of that bit,
//   - a legality flag.
// A saturating debug counter tracks how many illegal (non-monotonic) codes
// were accepted.
//
// A legal code is all zeros, or a contiguous run of ones from some bit k up
// to bit WIDTH-1. Illegal codes still decode to their lowest set bit, with
// err raised.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   thr_vld  in   input valid
//   thr_rdy  out  input ready (depends only on pry_rdy and internal valids)
//   thr      in   [WIDTH-1:0] thermometer code
//   pry_vld  out  output valid
//   pry_rdy  in   output ready
//   pry      out  [WIDTH-1:0] one-hot of the lowest set bit of thr (0 if none)
//   idx      out  [IDX_W-1:0] binary index of that bit (0 if none)
//   any      out  |thr
//   err      out  thr was not a legal thermometer code
//   err_cnt  out  [CNT_W-1:0] saturating count of accepted illegal codes
//   err_clr  in   synchronous clear of err_cnt (wins over an increment)
// -----------------------------------------------------------------------------
module thr_to_pry_pipe #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             thr_vld,
  output logic             thr_rdy,
  input  logic [WIDTH-1:0] thr,
  output logic             pry_vld,
  input  logic             pry_rdy,
  output logic [WIDTH-1:0] pry,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  // Stage 1 state
  logic             s1_vld_reg;
  logic [WIDTH-1:0] p1_reg;
  logic             any1_reg;
  logic             err1_reg;

  // Stage 2 state (drives the outputs directly)
  logic             s2_vld_reg;
  logic [WIDTH-1:0] pry_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             any_reg;
  logic             err_reg;

  logic [CNT_W-1:0] err_cnt_reg;

  // Handshake: a stage can take new data when it is empty or when its
  // contents leave in the same cycle.
  logic s1_rdy;
  logic s2_rdy;
  logic in_xfer;

  assign s2_rdy  = ~s2_vld_reg | pry_rdy;
  assign s1_rdy  = ~s1_vld_reg | s2_rdy;
  assign thr_rdy = s1_rdy;
  assign in_xfer = thr_vld & s1_rdy;

  // Stage 1 combinational decode of the incoming code.
  logic [WIDTH-1:0] p1_next;
  logic             err1_next;
  logic [WIDTH-2:0] fall_bits;

  // Two's-complement trick isolates the lowest set bit (0 stays 0).
  assign p1_next = thr & (~thr + WIDTH'(1));

  // A falling edge going upward (1 at bit i, 0 at bit i+1) breaks the
  // contiguous run of ones that must reach the MSB.
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_fall
    assign fall_bits[gi] = thr[gi] & ~thr[gi + 1];
  end

  assign err1_next = |fall_bits;

  // Stage 2 binary encode. p1_reg is one-hot or zero, so OR-ing the
  // indices of the set bits yields the index (or 0).
  logic [IDX_W-1:0] idx_next;

  always_comb begin
    idx_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (p1_reg[i]) begin
        idx_next = idx_next | IDX_W'(i);
      end
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_reg <= 1'b0;
      p1_reg     <= '0;
      any1_reg   <= 1'b0;
      err1_reg   <= 1'b0;
    end else if (s1_rdy) begin
      s1_vld_reg <= thr_vld;
      if (thr_vld) begin
        p1_reg   <= p1_next;
        any1_reg <= |thr;
        err1_reg <= err1_next;
      end
    end
  end

  // Stage 2 registers. When S1 is empty and S2 drains, valid drops so the
  // old result is never presented twice; the data simply stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_reg <= 1'b0;
      pry_reg    <= '0;
      idx_reg    <= '0;
      any_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else if (s2_rdy) begin
      s2_vld_reg <= s1_vld_reg;
      if (s1_vld_reg) begin
        pry_reg <= p1_reg;
        idx_reg <= idx_next;
        any_reg <= any1_reg;
        err_reg <= err1_reg;
      end
    end
  end

  // Illegal-code counter: counts at acceptance time, saturates at all-ones,
  // and a clear overrides a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (err_clr) begin
      err_cnt_reg <= '0;
    end else if (in_xfer && err1_next && (err_cnt_reg != {CNT_W{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + CNT_W'(1);
    end
  end

  assign pry_vld = s2_vld_reg;
  assign pry     = pry_reg;
  assign idx     = idx_reg;
  assign any     = any_reg;
  assign err     = err_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_thr_to_pry_pipe.sv
// -----------------------------------------------------------------------------
// tb_thr_to_pry_pipe
//
// Scoreboard bench for thr_to_pry_pipe (WIDTH=8). Stimulus pushes the
// expected result of every issued code into a queue. A negedge monitor pops
// and compares on each output transfer and checks that outputs stay frozen
// while stalled.
// -----------------------------------------------------------------------------
module tb_thr_to_pry_pipe;

  localparam int W  = 8;
  localparam int IW = 3;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          thr_vld;
  logic          thr_rdy;
  logic [W-1:0]  thr;
  logic          pry_vld;
  logic          pry_rdy;
  logic [W-1:0]  pry;
  logic [IW-1:0] idx;
  logic          any;
  logic          err;
  logic [CW-1:0] err_cnt;
  logic          err_clr;

  thr_to_pry_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .thr_vld (thr_vld),
    .thr_rdy (thr_rdy),
    .thr     (thr),
    .pry_vld (pry_vld),
    .pry_rdy (pry_rdy),
    .pry     (pry),
    .idx     (idx),
    .any     (any),
    .err     (err),
    .err_cnt (err_cnt),
    .err_clr (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  thr;
    logic [W-1:0]  pry;
    logic [IW-1:0] idx;
    logic          any;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   total   = 0;
  int   bad     = 0;
  int   acc_cnt = 0;
  int   cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] t, input logic [W-1:0] p,
                              input int i, input logic a, input logic e);
    exp_t r;
    r.thr = t; r.pry = p; r.idx = IW'(i); r.any = a; r.err = e;
    return r;
  endfunction

  // Reference model: scan upward for the first one; legal means the code
  // equals all-ones shifted up to that bit (or is zero).
  function automatic exp_t model(input logic [W-1:0] t);
    exp_t r;
    logic [W-1:0] ones;
    bit found;
    r.thr = t; r.pry = '0; r.idx = '0; r.any = (t != 0); r.err = 1'b0;
    found = 0;
    ones = '1;
    for (int i = 0; i < W; i++) begin
      if (!found && t[i]) begin
        found = 1;
        r.pry = W'(1) << i;
        r.idx = IW'(i);
        r.err = (t != (ones << i));
      end
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Input-side monitor: counts accepted transfers.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && thr_vld && thr_rdy) acc_cnt++;
    end
  end

  // Output-side monitor: scoreboard compare and stall-stability check.
  initial begin
    logic [W-1:0]  h_pry;
    logic [IW-1:0] h_idx;
    logic          h_any;
    logic          h_err;
    logic [W-1:0]  pre;
    bit            held;
    exp_t          e;
    held = 0;
    h_pry = '0; h_idx = '0; h_any = 0; h_err = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold_pry", 32'(pry), 32'(h_pry));
          chk("hold_idx", 32'(idx), 32'(h_idx));
          chk("hold_any_err", {30'd0, any, err}, {30'd0, h_any, h_err});
        end
        held  = pry_vld && !pry_rdy;
        h_pry = pry; h_idx = idx; h_any = any; h_err = err;
        if (pry_vld && pry_rdy) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 32'(pry), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("pry", 32'(pry), 32'(e.pry));
            chk("idx", 32'(idx), 32'(e.idx));
            chk("any", 32'(any), 32'(e.any));
            chk("err", 32'(err), 32'(e.err));
            if (!e.err) begin
              pre = '0;
              for (int i = 0; i < W; i++) begin
                pre[i] = pry[i] | ((i > 0) ? pre[i-1] : 1'b0);
              end
              chk("prefix_or", 32'(pre), 32'(e.thr));
            end
            $display("xfer thr=%02h pry=%02h idx=%0d any=%0b err=%0b cnt=%0d",
                     e.thr, pry, idx, any, err, err_cnt);
          end
        end
      end
    end
  end

  // Issue one code; called at posedge+1, returns at posedge+1 after acceptance.
  task automatic send(input logic [W-1:0] v, input exp_t e);
    int n;
    sb.push_back(e);
    thr = v;
    thr_vld = 1'b1;
    n = 0;
    @(negedge clk);
    while (!thr_rdy && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!thr_rdy) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    thr_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || pry_vld) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Latency from an idle pipe: accept edge, then valid after the next edge.
  task automatic latency_check(input logic [W-1:0] v, input exp_t e);
    sb.push_back(e);
    thr = v;
    thr_vld = 1'b1;
    chk("lat_rdy", 32'(thr_rdy), 32'd1);
    @(posedge clk);
    #1;
    thr_vld = 1'b0;
    chk("lat_vld_1", 32'(pry_vld), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_vld_2", 32'(pry_vld), 32'd1);
    wait_drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    int c0, a0;
    bit done;

    rst = 1'b1; thr_vld = 1'b0; thr = '0; pry_rdy = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pry_vld", 32'(pry_vld), 32'd0);
    chk("rst_pry", 32'(pry), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_any_err", {30'd0, any, err}, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_thr_rdy", 32'(thr_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero code, latency 2.
    latency_check(8'h00, mk(8'h00, 8'h00, 0, 0, 0));

    // All legal codes back to back: one accept per cycle.
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      v = 8'hFF << k;
      send(v, mk(v, 8'h01 << k, k, 1, 0));
    end
    chk("sweep_cycles", 32'(cyc - c0), 32'd8);
    wait_drain();
    chk("sweep_err_cnt", 32'(err_cnt), 32'd0);

    // Illegal code and counter saturation.
    send(8'b0101_1000, mk(8'b0101_1000, 8'b0000_1000, 3, 1, 1));
    wait_drain();
    chk("err_cnt_1", 32'(err_cnt), 32'd1);
    for (int k = 0; k < 300; k++) begin
      send(8'b0101_1000, mk(8'b0101_1000, 8'b0000_1000, 3, 1, 1));
    end
    wait_drain();
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Clear coincident with an illegal accept: clear wins.
    sb.push_back(mk(8'b0010_0110, 8'b0000_0010, 1, 1, 1));
    thr = 8'b0010_0110;
    thr_vld = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    chk("clr_rdy", 32'(thr_rdy), 32'd1);
    @(posedge clk);
    #1;
    thr_vld = 1'b0;
    err_clr = 1'b0;
    chk("err_cnt_clr", 32'(err_cnt), 32'd0);
    wait_drain();
    send(8'b0000_0001, mk(8'b0000_0001, 8'b0000_0001, 0, 1, 1));
    wait_drain();
    chk("err_cnt_after_clr", 32'(err_cnt), 32'd1);

    // Backpressure: 4 codes, output stalled for 5 cycles.
    pry_rdy = 1'b0;
    a0 = acc_cnt;
    fork
      begin
        send(8'hFE, mk(8'hFE, 8'h02, 1, 1, 0));
        send(8'hF8, mk(8'hF8, 8'h08, 3, 1, 0));
        send(8'hE0, mk(8'hE0, 8'h20, 5, 1, 0));
        send(8'h80, mk(8'h80, 8'h80, 7, 1, 0));
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_thr_rdy", 32'(thr_rdy), 32'd0);
        chk("bp_accepts", 32'(acc_cnt - a0), 32'd2);
        chk("bp_pry_vld", 32'(pry_vld), 32'd1);
        chk("bp_pry", 32'(pry), 32'h02);
        chk("bp_idx", 32'(idx), 32'd1);
        pry_rdy = 1'b1;
      end
    join
    wait_drain();
    chk("bp_accepts_all", 32'(acc_cnt - a0), 32'd4);

    // Random traffic with random output stalls.
    done = 0;
    fork
      begin
        for (int k = 0; k < 3000; k++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          case ($urandom_range(0, 3))
            0: v = 8'hFF << $urandom_range(0, 7);
            1: v = 8'h00;
            default: v = W'($urandom);
          endcase
          send(v, model(v));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          pry_rdy = ($urandom_range(0, 3) != 0);
        end
        pry_rdy = 1'b1;
      end
    join
    wait_drain();

    // Asynchronous reset with both stages full.
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    pry_rdy = 1'b0;
    send(8'b0011_0000, mk(8'b0011_0000, 8'h10, 4, 1, 1));
    send(8'hF0, mk(8'hF0, 8'h10, 4, 1, 0));
    @(posedge clk);
    #1;
    chk("full_thr_rdy", 32'(thr_rdy), 32'd0);
    chk("full_err_cnt", 32'(err_cnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pry_vld", 32'(pry_vld), 32'd0);
    chk("arst_pry", 32'(pry), 32'd0);
    chk("arst_idx", 32'(idx), 32'd0);
    chk("arst_any_err", {30'd0, any, err}, 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_thr_rdy", 32'(thr_rdy), 32'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    pry_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_pry_vld", 32'(pry_vld), 32'd0);
    latency_check(8'hC0, mk(8'hC0, 8'h40, 6, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
